// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO bundle between the EX stage / hazard unit and the mul/div sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] mt_data;
  logic             hilo_rd;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in_a, in_b, mthi, mtlo, mt_data, hilo_rd,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, in_a, in_b, mthi, mtlo, mt_data, hilo_rd,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier and restoring divider owning the MIPS HI/LO pair.
// Operands are reduced to magnitudes on accept; signs are restored in FIXUP.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t             state;
  state_t             state_next;
  logic               op_div;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (count == '0) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    a_neg     = ~bus.op[0] & bus.in_a[WIDTH-1];
    b_neg     = ~bus.op[0] & bus.in_b[WIDTH-1];
    mag_a     = a_neg ? -bus.in_a : bus.in_a;
    mag_b     = b_neg ? -bus.in_b : bus.in_b;
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_ge    = rem_shift >= {1'b0, divisor};
    rem_diff  = rem_shift[WIDTH-1:0] - divisor;
    if (!op_div) acc_step = {add_sum, acc[WIDTH-1:1]};
    else         acc_step = {(rem_ge ? rem_diff : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // A zero divisor must leave the all-ones quotient un-negated, so it never sets neg_res.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      divisor <= '0;
      acc     <= '0;
      count   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_r <= bus.mt_data;
          if (bus.mtlo) lo_r <= bus.mt_data;
          if (bus.start) begin
            op_div  <= bus.op[1];
            neg_res <= (a_neg ^ b_neg) & ~(bus.op[1] & (bus.in_b == '0));
            neg_rem <= a_neg;
            divisor <= mag_b;
            acc     <= {{WIDTH{1'b0}}, mag_a};
            count   <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          acc <= acc_step;
          if (count != '0) count <= count - CW'(1);
        end
        FIXUP: begin
          if (op_div) begin
            lo_r <= quo_fix;
            hi_r <= rem_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.hilo_rd | bus.mthi | bus.mtlo);
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer; results come from a 64-bit arithmetic model.
module tb_muldiv_sequencer;
  localparam int WIDTH = 32;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   busy_cycles;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus();

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        q = sq;
        r = sr;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; start is held across exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.in_a  = a;
    bus.in_b  = b;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int hrd_at, input int mthi_at, output int latency, output int busy_cnt);
    latency  = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.done) begin
        latency = k;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (k == hrd_at) begin
        bus.hilo_rd = 1'b1;
        #1 checkOutput("stall_hilo_rd", 64'(bus.stall), 64'd1);
      end
      if (k == mthi_at) begin
        bus.mthi    = 1'b1;
        bus.mt_data = 32'hDEAD_BEEF;
        #1 checkOutput("stall_mthi", 64'(bus.stall), 64'd1);
      end else begin
        bus.mthi = 1'b0;
      end
      @(negedge CLK);
    end
    if (latency == 0) checkOutput("done_timeout", 64'd0, 64'd1);
    if (hrd_at > 0) begin
      checkOutput("stall_released", 64'(bus.stall), 64'd0);
      bus.hilo_rd = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    bus.start   = 1'b0;
    bus.op      = 2'd0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.mt_data = '0;
    bus.hilo_rd = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    applyStimulus(2'd0, 32'hFFFF_FFFD, 32'd5);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("mult_latency", 64'(lat), 64'(WIDTH + 2));
    checkOutput("mult_busy_cycles", 64'(busy_cycles), 64'(WIDTH + 1));
    checkOutput("mult_busy_low", 64'(bus.busy), 64'd0);
    checkOutput("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    checkOutput("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);

    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    checkOutput("multu_lo", 64'(bus.lo), 64'h0000_0001);
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2);
    checkOutput("done_one_cycle", 64'(bus.done), 64'd0);
    checkOutput("b2b_busy", 64'(bus.busy), 64'd1);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("div_latency", 64'(lat), 64'(WIDTH + 2));
    checkOutput("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    checkOutput("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    applyStimulus(2'd3, 32'hFFFF_FFFF, 32'h10);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("divu_lo", 64'(bus.lo), 64'h0FFF_FFFF);
    checkOutput("divu_hi", 64'(bus.hi), 64'hF);
    applyStimulus(2'd2, 32'd100, 32'd0);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    checkOutput("div0_hi", 64'(bus.hi), 64'd100);
    applyStimulus(2'd2, 32'hFFFF_FFF0, 32'd0);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("div0_neg_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    checkOutput("div0_neg_hi", 64'(bus.hi), 64'hFFFF_FFF0);
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    checkOutput("div_ovf_hi", 64'(bus.hi), 64'd0);

    bus.mtlo    = 1'b1;
    bus.mt_data = 32'h1234;
    @(negedge CLK);
    bus.mtlo = 1'b0;
    checkOutput("mtlo_lo", 64'(bus.lo), 64'h1234);
    checkOutput("mtlo_hi_kept", 64'(bus.hi), 64'd0);

    bus.mthi    = 1'b1;
    bus.mt_data = 32'hABCD;
    applyStimulus(2'd1, 32'd7, 32'd6);
    bus.mthi = 1'b0;
    checkOutput("mthi_with_start_hi", 64'(bus.hi), 64'hABCD);
    checkOutput("mthi_with_start_busy", 64'(bus.busy), 64'd1);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("mthi_overwritten_hi", 64'(bus.hi), 64'd0);
    checkOutput("mthi_overwritten_lo", 64'(bus.lo), 64'd42);

    applyStimulus(2'd0, 32'd2, 32'd3);
    waitDone(5, 10, lat, busy_cycles);
    checkOutput("stalled_mult_hi", 64'(bus.hi), 64'd0);
    checkOutput("stalled_mult_lo", 64'(bus.lo), 64'd6);

    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (11) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_hi", 64'(bus.hi), 64'd0);
    checkOutput("abort_lo", 64'(bus.lo), 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    applyStimulus(2'd1, 32'd7, 32'd6);
    waitDone(0, 0, lat, busy_cycles);
    checkOutput("post_abort_lo", 64'(bus.lo), 64'd42);
    checkOutput("post_abort_hi", 64'(bus.hi), 64'd0);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 0)      rb = 32'd0;
      else if (i % 4 == 1) rb = 32'($urandom_range(1, 100));
      else if (i % 4 == 2) rb = -32'($urandom_range(1, 100));
      applyStimulus(rop, ra, rb);
      waitDone(0, 0, lat, busy_cycles);
      checkOutput($sformatf("rand%0d_op%0d_hilo", i, rop), {bus.hi, bus.lo}, refModel(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
